rev_intc: RTL



---
 rtl/rev_intc.sv | 101 ++++++++++
 1 files changed

// File: rtl/rev_intc.sv
// rev_intc: APB interrupt controller with per-source gateway, priority arbiter and claim/complete
module rev_intc #(
  parameter int NUM_SRC    = 8,
  parameter int PRIO_W     = 3,
  parameter int PADDR_SIZE = 4
) (
  input  logic                  pclk,
  input  logic                  prstn,
  input  logic                  psel,
  input  logic                  penable,
  input  logic [PADDR_SIZE-1:0] paddr,
  input  logic                  pwrite,
  input  logic [31:0]           pwrdata,
  input  logic [3:0]            pstrb,
  output logic                  pready,
  output logic [31:0]           prddata,
  output logic                  pslverr,
  input  logic [NUM_SRC-1:0]    src_i,
  output logic                  irq_o
);
  localparam int IW = 4;
  logic              rd, wr, claim, done, irq_q, unused_ok;
  logic [NUM_SRC-1:0] en_q, pend_q, pend_d, insvc_q, insvc_d;
  logic [PRIO_W-1:0] thr_q, best_d;
  logic [PRIO_W-1:0] prio_q [NUM_SRC];
  logic [IW-1:0]     cid_d, cid_q, wid;
  assign rd        = psel & penable & ~pwrite;
  assign wr        = psel & penable & pwrite;
  assign wid       = pwrdata[IW-1:0];
  assign claim     = rd && paddr == PADDR_SIZE'(3) && cid_q != '0;
  assign done      = wr && paddr == PADDR_SIZE'(3);
  assign pready    = 1'b1;
  assign pslverr   = 1'b0;
  assign irq_o     = irq_q;
  assign unused_ok = ^{pwrdata, pstrb};
  // Config registers: ENABLE, THRESHOLD and per-source PRIORITY, all gated by byte strobe 0
  always_ff @(posedge pclk or negedge prstn) begin
    if (!prstn) begin
      en_q  <= '0;
      thr_q <= '0;
      for (int i = 0; i < NUM_SRC; i++) prio_q[i] <= '0;
    end else if (wr && pstrb[0]) begin
      if (paddr == PADDR_SIZE'(1)) en_q <= pwrdata[NUM_SRC-1:0];
      if (paddr == PADDR_SIZE'(2)) thr_q <= pwrdata[PRIO_W-1:0];
      for (int i = 0; i < NUM_SRC; i++)
        if (paddr == PADDR_SIZE'(8 + i)) prio_q[i] <= pwrdata[PRIO_W-1:0];
    end
  end
  // Gateway next state: claim clears pending and marks in-service, complete releases in-service
  always_comb begin
    pend_d  = '0;
    insvc_d = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      pend_d[i]  = (claim && cid_q == IW'(i + 1)) ? 1'b0 : pend_q[i] | (src_i[i] & ~insvc_q[i]);
      insvc_d[i] = (claim && cid_q == IW'(i + 1)) ? 1'b1 :
                   (done && wid == IW'(i + 1))    ? 1'b0 : insvc_q[i];
    end
  end
  // Gateway state registers
  always_ff @(posedge pclk or negedge prstn) begin
    if (!prstn) begin
      pend_q  <= '0;
      insvc_q <= '0;
    end else begin
      pend_q  <= pend_d;
      insvc_q <= insvc_d;
    end
  end
  // Arbiter: highest priority wins, strict compare keeps the lowest ID on ties
  always_comb begin
    best_d = '0;
    cid_d  = '0;
    for (int i = 0; i < NUM_SRC; i++)
      if (pend_q[i] && en_q[i] && prio_q[i] > best_d) begin
        best_d = prio_q[i];
        cid_d  = IW'(i + 1);
      end
  end
  // Arbiter output registers: claim ID and interrupt request to the core
  always_ff @(posedge pclk or negedge prstn) begin
    if (!prstn) begin
      cid_q <= '0;
      irq_q <= 1'b0;
    end else begin
      cid_q <= cid_d;
      irq_q <= (cid_d != '0) && (best_d > thr_q);
    end
  end
  // Read mux, zero outside a read access
  always_comb begin
    prddata = '0;
    if (rd) begin
      if (paddr == PADDR_SIZE'(0)) prddata[NUM_SRC-1:0] = pend_q;
      if (paddr == PADDR_SIZE'(1)) prddata[NUM_SRC-1:0] = en_q;
      if (paddr == PADDR_SIZE'(2)) prddata[PRIO_W-1:0]  = thr_q;
      if (paddr == PADDR_SIZE'(3)) prddata[IW-1:0]      = cid_q;
      for (int i = 0; i < NUM_SRC; i++)
        if (paddr == PADDR_SIZE'(8 + i)) prddata[PRIO_W-1:0] = prio_q[i];
    end
  end
endmodule
